fir_mem_seq_ctrl: RTL and testbench

//  Sequencer that owns the port of the 4096x16 sample/coefficient memory (mem16kb) in the FIR datapath.
//  - Per accepted input sample: writes the sample into a circular history buffer, then streams N_TAPS (sample, coefficient) pairs to the MAC.
//  - Loads coefficients into memory while idle.
//  - Only master of mem16kb; drives address, data_in and write_enable_n.

---
 rtl/fir_mem_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fir_mem_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mem_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fir_mem_seq_ctrl
//
// Owns the single port of the 4096x16 sample/coefficient memory (mem16kb)
// in the FIR datapath. For each accepted input sample it:
//   1. writes the sample into a circular history buffer;
//   2. streams N_TAPS (x[n-k], h[k]) pairs to the MAC, one pair per two cycles.
// While idle it also lets coefficients be written into memory. Coefficient
// writes take priority over new samples.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input sample handshake; in_sample is the sample
//   coef_wr_en          single-cycle coefficient write request (idle only)
//   coef_addr/coef_data coefficient index and value
//   busy                high whenever a sample sequence is in progress
//   tap_valid           one-cycle pulse per tap pair, no backpressure
//   tap_first/tap_last  qualify tap_valid for k == 0 / k == N_TAPS-1
//   tap_sample/tap_coef x[n-k] / h[k]; both hold between pulses
//   mem_address         mem16kb address
//   mem_data_in         mem16kb write data
//   mem_write_enable_n  mem16kb write enable, 0 = write
//   mem_data_out        mem16kb read data, valid one cycle after its address
// ---------------------------------------------------------------------------
module fir_mem_seq_ctrl #(
    parameter int unsigned N_TAPS     = 32,
    parameter int unsigned RING_DEPTH = 64,
    parameter logic [11:0] RING_BASE  = 12'h800,
    parameter logic [11:0] COEF_BASE  = 12'h000,
    parameter int unsigned CA_W       = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_sample,
    input  logic            coef_wr_en,
    input  logic [CA_W-1:0] coef_addr,
    input  logic [15:0]     coef_data,
    output logic            busy,
    output logic            tap_valid,
    output logic            tap_first,
    output logic            tap_last,
    output logic [15:0]     tap_sample,
    output logic [15:0]     tap_coef,
    output logic [11:0]     mem_address,
    output logic [15:0]     mem_data_in,
    output logic            mem_write_enable_n,
    input  logic [15:0]     mem_data_out
);

    // Ring pointer width, and a one-bit-wider width for fill and the tap
    // index so that fill can reach RING_DEPTH itself.
    localparam int unsigned PW = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
    localparam int unsigned KW = PW + 1;
    localparam logic [KW-1:0] FILL_MAX = KW'(RING_DEPTH);
    localparam logic [KW-1:0] K_LAST   = KW'(N_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_RD_S,
        S_RD_C
    } state_t;

    state_t          state;
    logic            armed;      // low until the first clock after reset
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   p;          // ring slot of the sample being processed
    logic [KW-1:0]   fill;
    logic [KW-1:0]   k;
    logic [15:0]     sample_q;
    logic [15:0]     coef_hold;
    logic [PW-1:0]   rd_idx;

    // in_ready is held low during reset and for the release cycle, so the
    // first acceptance can only happen once the sequencer is clocking.
    assign in_ready = armed && (state == S_IDLE) && !coef_wr_en;
    assign busy     = (state != S_IDLE);

    // The coefficient arrives on mem_data_out in the very cycle tap_valid is
    // high, so it is passed straight through then and held afterwards.
    assign tap_coef = tap_valid ? mem_data_out : coef_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            wr_ptr     <= '0;
            p          <= '0;
            fill       <= '0;
            k          <= '0;
            sample_q   <= '0;
            coef_hold  <= '0;
            tap_valid  <= 1'b0;
            tap_first  <= 1'b0;
            tap_last   <= 1'b0;
            tap_sample <= '0;
        end else begin
            armed     <= 1'b1;
            tap_valid <= 1'b0;
            tap_first <= 1'b0;
            tap_last  <= 1'b0;
            if (tap_valid) begin
                coef_hold <= mem_data_out;
            end
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        sample_q <= in_sample;
                        p        <= wr_ptr;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill != FILL_MAX) begin
                        fill <= fill + 1'b1;
                    end
                    k     <= '0;
                    state <= S_RD_S;
                end
                S_RD_S: begin
                    state <= S_RD_C;
                end
                S_RD_C: begin
                    // mem_data_out now carries the sample read in RD_S.
                    // Slots never written since reset read as zero history.
                    tap_sample <= (k >= fill) ? 16'h0000 : mem_data_out;
                    tap_valid  <= 1'b1;
                    tap_first  <= (k == '0);
                    tap_last   <= (k == K_LAST);
                    if (k == K_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= S_RD_S;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_address        = '0;
        mem_data_in        = '0;
        mem_write_enable_n = 1'b1;
        // Wrap happens at PW bits before the index is widened to an address.
        rd_idx             = p - k[PW-1:0];
        case (state)
            S_IDLE: begin
                if (armed && coef_wr_en) begin
                    mem_address        = COEF_BASE + 12'(coef_addr);
                    mem_data_in        = coef_data;
                    mem_write_enable_n = 1'b0;
                end
            end
            S_WRITE: begin
                mem_address        = RING_BASE + 12'(p);
                mem_data_in        = sample_q;
                mem_write_enable_n = 1'b0;
            end
            S_RD_S: begin
                mem_address = RING_BASE + 12'(rd_idx);
            end
            S_RD_C: begin
                mem_address = COEF_BASE + 12'(k);
            end
            default: begin
                mem_address = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_mem_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_mem_seq_ctrl
//
// Bench for fir_mem_seq_ctrl with a behavioural mem16kb attached. Expected
// taps come from a list of samples accepted since the last reset and an
// array of loaded coefficients: tap k of the newest sample is the k-th most
// recent sample (or zero if fewer were taken) paired with h[k].
// ---------------------------------------------------------------------------
module tb_fir_mem_seq_ctrl;

    localparam int N  = 32;
    localparam int RD = 64;
    localparam logic [11:0] RB = 12'h800;
    localparam logic [11:0] CB = 12'h000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_sample = '0;
    logic        coef_wr_en = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        busy;
    logic        tap_valid;
    logic        tap_first;
    logic        tap_last;
    logic [15:0] tap_sample;
    logic [15:0] tap_coef;
    logic [11:0] mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_enable_n;
    logic [15:0] mem_data_out;

    always #5 clk = ~clk;

    fir_mem_seq_ctrl #(
        .N_TAPS(N),
        .RING_DEPTH(RD),
        .RING_BASE(RB),
        .COEF_BASE(CB),
        .CA_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sample(in_sample),
        .coef_wr_en(coef_wr_en),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .busy(busy),
        .tap_valid(tap_valid),
        .tap_first(tap_first),
        .tap_last(tap_last),
        .tap_sample(tap_sample),
        .tap_coef(tap_coef),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_write_enable_n(mem_write_enable_n),
        .mem_data_out(mem_data_out)
    );

    // mem16kb: synchronous write, registered read.
    logic [15:0] mem [4096];
    always @(posedge clk) begin
        if (!mem_write_enable_n) mem[mem_address] <= mem_data_in;
        mem_data_out <= mem[mem_address];
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          hist[$];
    logic [15:0] coef_m [N];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Asserts reset in the current cycle, checks the reset outputs, releases
    // it one cycle later and returns at the start of the first armed cycle.
    task automatic do_reset();
        rst_n      = 1'b0;
        coef_wr_en = 1'b1;
        coef_addr  = 5'($urandom_range(0, 31));
        coef_data  = 16'($urandom);
        in_valid   = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_tap_valid", tap_valid, 0);
        check("rst_tap_first", tap_first, 0);
        check("rst_tap_last", tap_last, 0);
        check("rst_wen_n", mem_write_enable_n, 1);
        check("rst_busy", busy, 0);
        check("rst_addr", mem_address, 0);
        check("rst_din", mem_data_in, 0);
        check("rst_tap_sample", tap_sample, 0);
        check("rst_tap_coef", tap_coef, 0);
        hist.delete();
        next_cycle();
        rst_n      = 1'b1;
        coef_wr_en = 1'b0;
        in_valid   = 1'b0;
        next_cycle();
    endtask

    task automatic idle_cycle();
        coef_wr_en = 1'b0;
        in_valid   = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_wen_n", mem_write_enable_n, 1);
        check("idle_addr", mem_address, 0);
        check("idle_busy", busy, 0);
        next_cycle();
    endtask

    task automatic load_coef(input int a, input logic [15:0] d, input bit with_valid);
        coef_wr_en = 1'b1;
        coef_addr  = 5'(a);
        coef_data  = d;
        in_valid   = with_valid;
        in_sample  = 16'($urandom);
        #1;
        check("cw_in_ready", in_ready, 0);
        check("cw_wen_n", mem_write_enable_n, 0);
        check("cw_addr", mem_address, CB + 12'(a));
        check("cw_din", mem_data_in, d);
        coef_m[a] = d;
        next_cycle();
    endtask

    // Offers sample s in the current cycle and follows the whole sequence,
    // returning at the start of the first idle cycle (last tap valid there).
    // abort_at > 0 resets the block at that cycle of the sequence.
    task automatic run_sample(input logic [15:0] s, input bit hold, input int abort_at);
        int n;
        int p;
        int k;
        int exp_s;
        bit tv;
        coef_wr_en = 1'b0;
        in_valid   = 1'b1;
        in_sample  = s;
        #1;
        check("acc_in_ready", in_ready, 1);
        check("acc_busy", busy, 0);
        hist.push_back(int'(s));
        n = hist.size();
        p = (n - 1) % RD;
        for (int c = 1; c <= 2 * N + 2; c++) begin
            next_cycle();
            if (c == abort_at) begin
                do_reset();
                return;
            end
            tv = (c >= 4) && (c % 2 == 0);
            check("tap_valid", tap_valid, tv);
            if (tv) begin
                k = (c - 4) / 2;
                exp_s = (k < n) ? hist[n - 1 - k] : 0;
                check("tap_first", tap_first, (k == 0));
                check("tap_last", tap_last, (k == N - 1));
                check("tap_sample", tap_sample, exp_s);
                check("tap_coef", tap_coef, coef_m[k]);
            end
            if (c == 2 * N + 2) begin
                check("end_busy", busy, 0);
                return;
            end
            if (hold) begin
                in_valid   = 1'b1;
                coef_wr_en = 1'b0;
            end else begin
                in_valid   = 1'($urandom_range(0, 1));
                in_sample  = 16'($urandom);
                coef_wr_en = ($urandom_range(0, 3) == 0);
                coef_addr  = 5'($urandom_range(0, 31));
                coef_data  = 16'($urandom);
            end
            #1;
            check("seq_busy", busy, 1);
            check("seq_in_ready", in_ready, 0);
            if (c == 1) begin
                check("wr_wen_n", mem_write_enable_n, 0);
                check("wr_addr", mem_address, RB + 12'(p));
                check("wr_data", mem_data_in, s);
            end else if (c % 2 == 0) begin
                k = (c - 2) / 2;
                check("rds_wen_n", mem_write_enable_n, 1);
                check("rds_addr", mem_address, RB + 12'((((n - 1 - k) % RD) + RD) % RD));
            end else begin
                k = (c - 3) / 2;
                check("rdc_wen_n", mem_write_enable_n, 1);
                check("rdc_addr", mem_address, CB + 12'(k));
            end
        end
    endtask

    initial begin
        #2;
        // Reset state, release, first armed cycle.
        do_reset();

        // Ramp coefficients, then one sample into an empty history.
        for (int k = 0; k < N; k++) load_coef(k, 16'(k + 1), 1'b0);
        run_sample(16'h0005, 1'b0, 0);
        idle_cycle();

        // 70 samples back to back from a fresh reset; the ring wraps.
        do_reset();
        for (int i = 1; i <= 70; i++) run_sample(16'(i), 1'b1, 0);
        idle_cycle();

        // Coefficient write and sample offered together, then accepted.
        load_coef($urandom_range(0, N - 1), 16'($urandom), 1'b1);
        run_sample(16'($urandom), 1'b0, 0);

        // Reset in the middle of a sequence, then restart from slot 0.
        run_sample(16'($urandom), 1'b0, 20);
        run_sample(16'($urandom), 1'b0, 0);
        run_sample(16'($urandom), 1'b0, 0);

        // Randomized mix of coefficient loads, samples and aborts.
        for (int it = 0; it < 14; it++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                if ($urandom_range(0, 1) == 1)
                    load_coef($urandom_range(0, N - 1), 16'($urandom), 1'($urandom_range(0, 1)));
                else
                    idle_cycle();
            end
            if ($urandom_range(0, 5) == 0)
                run_sample(16'($urandom), 1'b0, $urandom_range(1, 2 * N + 1));
            else
                run_sample(16'($urandom), 1'b0, 0);
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
